// File: rtl/lenet_pkg.sv
// Shared LeNet constants: default datapath widths, per-layer map sizes
// and the requantization shift used by the post-convolution stages.
package lenet_pkg;

    localparam int BIT_WIDTH_DEF = 8;
    localparam int OUT_WIDTH_DEF = 32;
    localparam int C1_SIZE       = 28;
    localparam int C3_SIZE       = 10;
    localparam int REQ_SHIFT     = 8;

    // Side length of a map after 2x2 / stride-2 pooling.
    function automatic int half_size(input int s);
        return s / 2;
    endfunction

endpackage

// File: rtl/relu_requant.sv
// Combinational ReLU + requantize (shift, optional round, saturate).
// Macro RELU_POOL_ROUND_EN: round half up before the shift instead of floor.
module relu_requant
    import lenet_pkg::*;
#(
    parameter int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int SHIFT     = REQ_SHIFT
) (
    input  logic signed [OUT_WIDTH-1:0] din,
    output logic        [BIT_WIDTH-1:0] q
);

    // One extra bit so the rounding add can never wrap.
    localparam int SW = OUT_WIDTH + 1;
    localparam logic [SW-1:0] QMAX = SW'((64'd1 << (BIT_WIDTH - 1)) - 64'd1);

    if (SHIFT < 1 || SHIFT > OUT_WIDTH - BIT_WIDTH) begin : g_shift_chk
        $fatal(1, "relu_requant: SHIFT out of range");
    end

    logic [SW-1:0] relu;
    logic [SW-1:0] sum;
    logic [SW-1:0] sh;

    // Clamp negatives, shift out fraction, saturate on the wide value.
    always_comb begin
        relu = din[OUT_WIDTH-1] ? '0 : {1'b0, din};
`ifdef RELU_POOL_ROUND_EN
        sum  = relu + (SW'(1) << (SHIFT - 1));
`else
        sum  = relu;
`endif
        sh   = sum >> SHIFT;
        q    = (sh > QMAX) ? QMAX[BIT_WIDTH-1:0] : sh[BIT_WIDTH-1:0];
    end

endmodule

// File: rtl/relu_maxpool22.sv
// ReLU + requant + 2x2/stride-2 max-pool over a raster conv stream.
// Macro RELU_POOL_ROUND_EN selects round-half-up requantization.
module relu_maxpool22
    import lenet_pkg::*;
#(
    parameter int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int IN_SIZE   = C3_SIZE,
    parameter int SHIFT     = REQ_SHIFT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic signed [OUT_WIDTH-1:0]       convValue,
    output logic                              out_valid,
    output logic signed [BIT_WIDTH-1:0]       out_value,
    output logic [$clog2(IN_SIZE/2)-1:0]      out_row,
    output logic [$clog2(IN_SIZE/2)-1:0]      out_col,
    output logic                              frame_done
);

    localparam int PN = half_size(IN_SIZE);
    localparam int PW = $clog2(PN);
    localparam int CW = $clog2(IN_SIZE);
    localparam logic [CW-1:0] LAST = CW'(IN_SIZE - 1);

    if (IN_SIZE % 2 != 0) begin : g_size_chk
        $fatal(1, "relu_maxpool22: IN_SIZE must be even");
    end

    logic [CW-1:0]        col;
    logic [CW-1:0]        row;
    logic [BIT_WIDTH-1:0] rq;

    logic                 s1_valid;
    logic [BIT_WIDTH-1:0] s1_q;
    logic [CW-1:0]        s1_col;
    logic [CW-1:0]        s1_row;

    logic [BIT_WIDTH-1:0] pair;
    logic [BIT_WIDTH-1:0] rowbuf [PN];
    logic [PW-1:0]        bidx;
    logic [BIT_WIDTH-1:0] rbv;
    logic [BIT_WIDTH-1:0] h;
    logic [BIT_WIDTH-1:0] pool;

    relu_requant #(
        .BIT_WIDTH (BIT_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_rq (
        .din (convValue),
        .q   (rq)
    );

    // Raster position of the next accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (col == LAST) begin
                col <= '0;
                row <= (row == LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Stage 1: register requantized sample with its position tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q   <= rq;
                s1_col <= col;
                s1_row <= row;
            end
        end
    end

    // Horizontal and vertical maxima; q is never negative so unsigned is safe.
    always_comb begin
        bidx = PW'(s1_col >> 1);
        rbv  = rowbuf[bidx];
        h    = (s1_q > pair) ? s1_q : pair;
        pool = (rbv > h) ? rbv : h;
    end

    // Stage 2: pair capture and pooled output on odd row / odd column.
    always_ff @(posedge clk) begin
        if (rst) begin
            pair       <= '0;
            out_valid  <= 1'b0;
            out_value  <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (s1_valid) begin
                if (!s1_col[0]) begin
                    pair <= s1_q;
                end else if (s1_row[0]) begin
                    out_valid  <= 1'b1;
                    out_value  <= pool;
                    out_row    <= PW'(s1_row >> 1);
                    out_col    <= bidx;
                    frame_done <= (s1_row == LAST) && (s1_col == LAST);
                end
            end
        end
    end

    // Even-row horizontal maxima; always rewritten before being read.
    always_ff @(posedge clk) begin
        if (s1_valid && s1_col[0] && !s1_row[0]) begin
            rowbuf[bidx] <= h;
        end
    end

endmodule

// File: tb/tb_relu_maxpool22.sv
// Directed bench for relu_maxpool22: requant, ramp, gaps, reset,
// back-to-back frames.
module tb_relu_maxpool22;

    localparam int BW = 8;
    localparam int OW = 32;
    localparam int N  = 10;
    localparam int PW = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic signed [OW-1:0] convValue;
    logic                 out_valid;
    logic signed [BW-1:0] out_value;
    logic [PW-1:0]        out_row;
    logic [PW-1:0]        out_col;
    logic                 frame_done;

    relu_maxpool22 dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .convValue  (convValue),
        .out_valid  (out_valid),
        .out_value  (out_value),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;
        int r;
        int c;
        int fd;
        int cy;
    } ev_t;

    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  stray_fd = 0;
    ev_t evq[$];
    int  ccyc[$];
    int  fv[100];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid)
            evq.push_back('{int'(out_value), int'(out_row), int'(out_col),
                            int'(frame_done), cyc});
        else if (frame_done)
            stray_fd++;
    end

    task automatic fill_ramp(input int off);
        for (int i = 0; i < 100; i++)
            fv[i] = ((i / 10) * 10 + (i % 10) + off) << 8;
    endtask

    task automatic send_one(input int i);
        @(negedge clk);
        in_valid  = 1'b1;
        convValue = fv[i];
        if (((i / 10) % 2 == 1) && ((i % 10) % 2 == 1))
            ccyc.push_back(cyc);
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < 100; i++) begin
            send_one(i);
            repeat (gap) begin
                @(negedge clk);
                in_valid  = 1'b0;
                convValue = 32'h0BAD_0BAD;
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        convValue = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset out_valid got %b want 0", out_valid);
        end
        n_tests++;
        if (out_value !== 8'sd0) begin
            n_fail++;
            $display("FAIL reset out_value got %0d want 0", out_value);
        end
        n_tests++;
        if ({out_row, out_col} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset row/col got %0d/%0d want 0/0", out_row, out_col);
        end
        n_tests++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset frame_done got %b want 0", frame_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_requant;
        int tbl[9];
        int exp9[9];
        tbl = '{300, 400, -5000, 100000, 127, 128, 32767, 255, 256};
`ifdef RELU_POOL_ROUND_EN
        exp9 = '{1, 2, 0, 127, 0, 1, 127, 1, 1};
`else
        exp9 = '{1, 1, 0, 127, 0, 0, 127, 0, 1};
`endif
        for (int i = 0; i < 100; i++) begin
            int b;
            b = ((i / 10) / 2) * 5 + ((i % 10) / 2);
            fv[i] = (b < 9) ? tbl[b] : 0;
        end
        evq.delete();
        ccyc.delete();
        send_frame(0);
        idle(4);
        n_tests++;
        if (evq.size() !== 25) begin
            n_fail++;
            $display("FAIL requant count got %0d want 25", evq.size());
        end
        for (int i = 0; i < 25 && i < evq.size(); i++) begin
            int e;
            e = (i < 9) ? exp9[i] : 0;
            n_tests++;
            if (evq[i].v !== e) begin
                n_fail++;
                $display("FAIL requant[%0d] value got %0d want %0d", i, evq[i].v, e);
            end
        end
    endtask

    task automatic test_ramp;
        fill_ramp(0);
        evq.delete();
        ccyc.delete();
        send_frame(0);
        idle(4);
        n_tests++;
        if (evq.size() !== 25) begin
            n_fail++;
            $display("FAIL ramp count got %0d want 25", evq.size());
        end
        for (int i = 0; i < 25 && i < evq.size(); i++) begin
            int r;
            int c;
            r = i / 5;
            c = i % 5;
            n_tests++;
            if (evq[i].v !== (2 * r + 1) * 10 + 2 * c + 1) begin
                n_fail++;
                $display("FAIL ramp[%0d] value got %0d want %0d", i, evq[i].v,
                         (2 * r + 1) * 10 + 2 * c + 1);
            end
            n_tests++;
            if (evq[i].r !== r || evq[i].c !== c) begin
                n_fail++;
                $display("FAIL ramp[%0d] index got %0d,%0d want %0d,%0d", i,
                         evq[i].r, evq[i].c, r, c);
            end
            n_tests++;
            if (evq[i].cy !== ccyc[i] + 2) begin
                n_fail++;
                $display("FAIL ramp[%0d] latency got %0d want 2", i, evq[i].cy - ccyc[i]);
            end
            n_tests++;
            if (evq[i].fd !== int'(i == 24)) begin
                n_fail++;
                $display("FAIL ramp[%0d] frame_done got %0d want %0d", i, evq[i].fd, i == 24);
            end
        end
    endtask

    task automatic test_gapped;
        fill_ramp(0);
        evq.delete();
        ccyc.delete();
        send_frame(2);
        idle(4);
        n_tests++;
        if (evq.size() !== 25) begin
            n_fail++;
            $display("FAIL gapped count got %0d want 25", evq.size());
        end
        for (int i = 0; i < 25 && i < evq.size(); i++) begin
            int r;
            int c;
            r = i / 5;
            c = i % 5;
            n_tests++;
            if (evq[i].v !== (2 * r + 1) * 10 + 2 * c + 1 ||
                evq[i].r !== r || evq[i].c !== c) begin
                n_fail++;
                $display("FAIL gapped[%0d] got %0d@%0d,%0d want %0d@%0d,%0d", i,
                         evq[i].v, evq[i].r, evq[i].c,
                         (2 * r + 1) * 10 + 2 * c + 1, r, c);
            end
            n_tests++;
            if (evq[i].cy !== ccyc[i] + 2) begin
                n_fail++;
                $display("FAIL gapped[%0d] latency got %0d want 2", i, evq[i].cy - ccyc[i]);
            end
        end
    endtask

    task automatic test_mid_reset;
        fill_ramp(0);
        for (int i = 0; i < 37; i++) send_one(i);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || out_value !== 8'sd0 ||
            out_row !== 3'd0 || out_col !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst outputs got v%b %0d %0d,%0d want v0 0 0,0",
                     out_valid, out_value, out_row, out_col);
        end
        rst = 1'b0;
        evq.delete();
        idle(6);
        n_tests++;
        if (evq.size() !== 0) begin
            n_fail++;
            $display("FAIL midrst stray out_valid got %0d want 0", evq.size());
        end
        evq.delete();
        ccyc.delete();
        send_frame(0);
        idle(4);
        n_tests++;
        if (evq.size() !== 25) begin
            n_fail++;
            $display("FAIL midrst count got %0d want 25", evq.size());
        end
        for (int i = 0; i < 25 && i < evq.size(); i++) begin
            int r;
            int c;
            r = i / 5;
            c = i % 5;
            n_tests++;
            if (evq[i].v !== (2 * r + 1) * 10 + 2 * c + 1 ||
                evq[i].r !== r || evq[i].c !== c || evq[i].fd !== int'(i == 24)) begin
                n_fail++;
                $display("FAIL midrst[%0d] got %0d@%0d,%0d fd%0d want %0d@%0d,%0d", i,
                         evq[i].v, evq[i].r, evq[i].c, evq[i].fd,
                         (2 * r + 1) * 10 + 2 * c + 1, r, c);
            end
        end
    endtask

    task automatic test_back_to_back;
        int nfd;
        nfd = 0;
        evq.delete();
        ccyc.delete();
        fill_ramp(0);
        send_frame(0);
        fill_ramp(5);
        send_frame(0);
        idle(4);
        n_tests++;
        if (evq.size() !== 50) begin
            n_fail++;
            $display("FAIL b2b count got %0d want 50", evq.size());
        end
        for (int i = 0; i < 50 && i < evq.size(); i++) begin
            int k;
            int e;
            k = i % 25;
            e = (2 * (k / 5) + 1) * 10 + 2 * (k % 5) + 1 + ((i >= 25) ? 5 : 0);
            nfd += evq[i].fd;
            n_tests++;
            if (evq[i].v !== e || evq[i].fd !== int'(k == 24)) begin
                n_fail++;
                $display("FAIL b2b[%0d] got %0d fd%0d want %0d fd%0d", i,
                         evq[i].v, evq[i].fd, e, k == 24);
            end
        end
        n_tests++;
        if (nfd !== 2) begin
            n_fail++;
            $display("FAIL b2b frame_done pulses got %0d want 2", nfd);
        end
    endtask

    initial begin
        test_reset();
        test_requant();
        test_ramp();
        test_gapped();
        test_mid_reset();
        test_back_to_back();
        n_tests++;
        if (stray_fd !== 0) begin
            n_fail++;
            $display("FAIL frame_done without out_valid got %0d want 0", stray_fd);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
